// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator. It compares two WIDTH-bit operands
// DIGIT bits per clock, starting with the MSB digit, and stops at the first
// digit that differs. Signed mode is handled by inverting the operand sign
// bits when the operands are captured. After that, every digit compare is
// unsigned.
module serial_magnitude_comparator #(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] DataIn0,
  input  logic [WIDTH-1:0] DataIn1,
  output logic             Busy,
  output logic             Done,
  output logic             GT_Out,
  output logic             LT_Out,
  output logic             EQ_Out
);

  localparam int NSTEP  = WIDTH / DIGIT;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);
  localparam logic [WIDTH-1:0]  MSB_MASK  = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              gt_q, gt_d;
  logic              lt_q, lt_d;
  logic              eq_q, eq_d;

  logic              signed_mode;
  logic [WIDTH-1:0]  sign_flip;
  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  assign signed_mode = (SIGNED_EN != 0) && Signed;
  assign sign_flip   = signed_mode ? MSB_MASK : '0;

  // The operands shift left after each equal digit. This keeps the digit
  // under test in the top DIGIT bits.
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == DONE);
  assign GT_Out = gt_q;
  assign LT_Out = lt_q;
  assign EQ_Out = eq_q;

  // Next-state, operand shifting and result flag logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          // A Start in the DONE cycle is accepted as well, so compares can
          // run back to back.
          a_d     = DataIn0 ^ sign_flip;
          b_d     = DataIn1 ^ sign_flip;
          step_d  = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (a_dig != b_dig) begin
          gt_d    = (a_dig > b_dig);
          lt_d    = (a_dig < b_dig);
          state_d = DONE;
        end else if (step_q == LAST_STEP) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          a_d    = a_q << DIGIT;
          b_d    = b_q << DIGIT;
          step_d = step_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, step and result flag registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      step_q <= '0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      step_q <= step_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
      eq_q   <= eq_d;
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed testbench for serial_magnitude_comparator with WIDTH=16, DIGIT=4
// and signed mode enabled.
module tb_serial_magnitude_comparator;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic        Signed;
  logic [15:0] DataIn0;
  logic [15:0] DataIn1;
  logic        Busy;
  logic        Done;
  logic        GT_Out;
  logic        LT_Out;
  logic        EQ_Out;

  int n_tests;
  int n_fail;
  int lat;
  int busy_cnt;

  serial_magnitude_comparator #(
    .WIDTH    (16),
    .DIGIT    (4),
    .SIGNED_EN(1)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .Signed (Signed),
    .DataIn0(DataIn0),
    .DataIn1(DataIn1),
    .Busy   (Busy),
    .Done   (Done),
    .GT_Out (GT_Out),
    .LT_Out (LT_Out),
    .EQ_Out (EQ_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic gt, input logic lt, input logic eq);
    check({tag, "_gt"}, {31'd0, GT_Out}, {31'd0, gt});
    check({tag, "_lt"}, {31'd0, LT_Out}, {31'd0, lt});
    check({tag, "_eq"}, {31'd0, EQ_Out}, {31'd0, eq});
  endtask

  // Drive Start for one edge. Returns 1 time unit after the accept edge.
  task automatic start_cmp(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge Clk);
    Start   = 1'b1;
    DataIn0 = a;
    DataIn1 = b;
    Signed  = s;
    @(posedge Clk);
    #1;
    Start   = 1'b0;
    DataIn0 = 16'h0000;
    DataIn1 = 16'h0000;
    Signed  = 1'b0;
  endtask

  // Count edges until Done is high. The wait is bounded; a timeout counts as a failure.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!Done && edges < 50) begin
      @(posedge Clk);
      #1;
      edges++;
    end
    check("done_timeout", {31'd0, Done}, 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Rst_n   = 1'b0;
    Start   = 1'b0;
    Signed  = 1'b0;
    DataIn0 = 16'h0000;
    DataIn1 = 16'h0000;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // T1: the last digit differs, so the result takes 4 cycles.
    start_cmp(16'h1234, 16'h1235, 1'b0);
    check("t1_busy", {31'd0, Busy}, 32'd1);
    wait_done(lat);
    check("t1_lat", lat, 32'd4);
    check_flags("t1", 1'b0, 1'b1, 1'b0);

    // T6: Start is accepted in T1's DONE cycle.
    Start   = 1'b1;
    DataIn0 = 16'hFFFF;
    DataIn1 = 16'h0000;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    check("t6_done_fell", {31'd0, Done}, 32'd0);
    check("t6_busy", {31'd0, Busy}, 32'd1);
    check_flags("t6_clr", 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    check("t6_lat", lat, 32'd1);
    check_flags("t6", 1'b1, 1'b0, 1'b0);

    // T2: the same operands give opposite results in unsigned and signed mode.
    start_cmp(16'h8000, 16'h0001, 1'b0);
    wait_done(lat);
    check("t2u_lat", lat, 32'd1);
    check_flags("t2u", 1'b1, 1'b0, 1'b0);
    start_cmp(16'h8000, 16'h0001, 1'b1);
    wait_done(lat);
    check("t2s_lat", lat, 32'd1);
    check_flags("t2s", 1'b0, 1'b1, 1'b0);

    // Signed: -1 < 1, decided on the first digit.
    start_cmp(16'hFFFF, 16'h0001, 1'b1);
    wait_done(lat);
    check("sneg_lat", lat, 32'd1);
    check_flags("sneg", 1'b0, 1'b1, 1'b0);

    // Signed: positive operands that differ only in the last digit.
    start_cmp(16'h7FF0, 16'h7FF1, 1'b1);
    wait_done(lat);
    check("spos_lat", lat, 32'd4);
    check_flags("spos", 1'b0, 1'b1, 1'b0);

    // T3: equal operands keep Busy high for 4 cycles, Done lasts one cycle,
    // and the flags hold while idle.
    start_cmp(16'hABCD, 16'hABCD, 1'b0);
    busy_cnt = 0;
    lat = 0;
    while (!Done && lat < 50) begin
      if (Busy) busy_cnt++;
      @(posedge Clk);
      #1;
      lat++;
    end
    check("t3_lat", lat, 32'd4);
    check("t3_busy_cycles", busy_cnt, 32'd4);
    check_flags("t3", 1'b0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    check("t3_done_width", {31'd0, Done}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_eq", {31'd0, EQ_Out}, 32'd1);
      @(posedge Clk);
      #1;
    end
    check_flags("t3_hold", 1'b0, 1'b0, 1'b1);

    // T4: a Start pulse during RUN is ignored.
    start_cmp(16'h0100, 16'h0200, 1'b0);
    Start   = 1'b1;
    DataIn0 = 16'hFFFF;
    DataIn1 = 16'h0000;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_done(lat);
    check("t4_lat", lat + 1, 32'd2);
    check_flags("t4", 1'b0, 1'b1, 1'b0);

    // T5: reset asserted mid-RUN at step 2.
    start_cmp(16'h1111, 16'h1111, 1'b0);
    repeat (2) @(posedge Clk);
    #2;
    check("t5_busy_pre", {31'd0, Busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, Busy}, 32'd0);
    check("t5_done", {31'd0, Done}, 32'd0);
    check_flags("t5_rst", 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    start_cmp(16'h0005, 16'h0003, 1'b0);
    wait_done(lat);
    check("t5_lat", lat, 32'd4);
    check_flags("t5", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
